// File: rtl/lease_table_loader_if.sv
// Host stream plus LLT write-port bundle between the host/LLT side (master)
// and the loader (slave).
interface lease_table_loader_if #(
  parameter int BW_DATA           = 32,
  parameter int BW_REF_ADDR       = 32,
  parameter int BW_LEASE_REGISTER = 32,
  parameter int BW_ADDR           = 8
);
  logic [BW_DATA-1:0]           data_i;
  logic                         valid_i;
  logic                         ready_o;
  logic [BW_ADDR-1:0]           addr_o;
  logic                         wren_ref_addr_o;
  logic                         wren_lease_o;
  logic                         rmen_o;
  logic [BW_REF_ADDR-1:0]       ref_addr_o;
  logic [BW_LEASE_REGISTER-1:0] ref_lease_o;

  modport slave (
    input  data_i, valid_i,
    output ready_o, addr_o, wren_ref_addr_o, wren_lease_o, rmen_o,
           ref_addr_o, ref_lease_o
  );

  modport master (
    output data_i, valid_i,
    input  ready_o, addr_o, wren_ref_addr_o, wren_lease_o, rmen_o,
           ref_addr_o, ref_lease_o
  );
endinterface

// File: rtl/lease_table_loader.sv
// Write-side sequencer for the dual-table lease lookup table: streams entries in
// an order that keeps each entry invalid until its final lease0 write.
module lease_table_loader #(
  parameter int N_ENTRIES         = 128,
  parameter int BW_LEASE_REGISTER = 32,
  parameter int BW_REF_ADDR       = 32,
  parameter int BW_DATA           = 32
) (
  input  logic                      clock_i,
  input  logic                      reset_i,
  input  logic                      start_i,
  input  logic                      clear_i,
  lease_table_loader_if.slave       llt_bus,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      error_o,
  output logic [$clog2(N_ENTRIES):0] loaded_o
);
  localparam int BW_ENTRIES = $clog2(N_ENTRIES);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_HDR, S_INVAL, S_L1, S_PROB, S_REF, S_L0
  } state_t;

  state_t                       r_state, w_state_next;
  logic [BW_ENTRIES-1:0]        r_idx, w_idx_next;
  logic [BW_ENTRIES:0]          r_cnt, w_cnt_next;
  logic [BW_ENTRIES:0]          r_loaded, w_loaded_next;
  logic [BW_ENTRIES:0]          r_addr, w_addr_next;
  logic                         r_wren_ref, w_wren_ref_next;
  logic                         r_wren_lease, w_wren_lease_next;
  logic                         r_rmen, w_rmen_next;
  logic [BW_REF_ADDR-1:0]       r_ref_addr, w_ref_addr_next;
  logic [BW_LEASE_REGISTER-1:0] r_ref_lease, w_ref_lease_next;
  logic                         r_done, w_done_next;
  logic                         r_error, w_error_next;

  logic                         w_ready;
  logic                         w_accept;
  logic [15:0]                  w_hdr_cnt;
  logic                         w_last_entry;

  assign w_hdr_cnt    = llt_bus.data_i[15:0];
  assign w_accept     = llt_bus.valid_i & w_ready;
  assign w_last_entry = ({1'b0, r_idx} == (r_cnt - 1'b1));

  always_comb begin
    w_state_next      = r_state;
    w_idx_next        = r_idx;
    w_cnt_next        = r_cnt;
    w_loaded_next     = r_loaded;
    w_addr_next       = r_addr;
    w_ref_addr_next   = r_ref_addr;
    w_ref_lease_next  = r_ref_lease;
    w_wren_ref_next   = 1'b0;
    w_wren_lease_next = 1'b0;
    w_rmen_next       = 1'b0;
    w_done_next       = 1'b0;
    w_error_next      = 1'b0;
    w_ready           = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (clear_i) begin
          w_state_next = S_CLEAR;
          w_idx_next   = '0;
        end else if (start_i) begin
          w_state_next = S_HDR;
        end
      end
      S_CLEAR: begin
        w_rmen_next = 1'b1;
        w_addr_next = {1'b0, r_idx};
        if (r_idx == BW_ENTRIES'(N_ENTRIES - 1)) begin
          w_done_next  = 1'b1;
          w_idx_next   = '0;
          w_state_next = S_IDLE;
        end else begin
          w_idx_next = r_idx + 1'b1;
        end
      end
      S_HDR: begin
        w_ready = 1'b1;
        if (w_accept) begin
          if (w_hdr_cnt == 16'd0) begin
            w_done_next   = 1'b1;
            w_loaded_next = '0;
            w_state_next  = S_IDLE;
          end else if (w_hdr_cnt > 16'(N_ENTRIES)) begin
            // Illegal count: leave the table and the previous loaded count alone.
            w_error_next = 1'b1;
            w_state_next = S_IDLE;
          end else begin
            w_cnt_next    = w_hdr_cnt[BW_ENTRIES:0];
            w_idx_next    = '0;
            w_loaded_next = '0;
            w_state_next  = S_INVAL;
          end
        end
      end
      S_INVAL: begin
        w_rmen_next  = 1'b1;
        w_addr_next  = {1'b0, r_idx};
        w_state_next = S_L1;
      end
      S_L1: begin
        w_ready = 1'b1;
        if (w_accept) begin
          w_wren_ref_next = 1'b1;
          w_addr_next     = {1'b1, r_idx};
          w_ref_addr_next = llt_bus.data_i[BW_REF_ADDR-1:0];
          w_state_next    = S_PROB;
        end
      end
      S_PROB: begin
        w_ready = 1'b1;
        if (w_accept) begin
          w_wren_lease_next = 1'b1;
          w_addr_next       = {1'b1, r_idx};
          w_ref_lease_next  = BW_LEASE_REGISTER'(llt_bus.data_i[8:0]);
          w_state_next      = S_REF;
        end
      end
      S_REF: begin
        w_ready = 1'b1;
        if (w_accept) begin
          w_wren_ref_next = 1'b1;
          w_addr_next     = {1'b0, r_idx};
          w_ref_addr_next = llt_bus.data_i[BW_REF_ADDR-1:0];
          w_state_next    = S_L0;
        end
      end
      S_L0: begin
        w_ready = 1'b1;
        if (w_accept) begin
          // lease0 write sets the valid bit, so it must be the last write of the entry.
          w_wren_lease_next = 1'b1;
          w_addr_next       = {1'b0, r_idx};
          w_ref_lease_next  = llt_bus.data_i[BW_LEASE_REGISTER-1:0];
          w_loaded_next     = r_loaded + 1'b1;
          if (w_last_entry) begin
            w_done_next  = 1'b1;
            w_state_next = S_IDLE;
          end else begin
            w_idx_next   = r_idx + 1'b1;
            w_state_next = S_INVAL;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_loaded     <= '0;
      r_addr       <= '0;
      r_wren_ref   <= 1'b0;
      r_wren_lease <= 1'b0;
      r_rmen       <= 1'b0;
      r_ref_addr   <= '0;
      r_ref_lease  <= '0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_idx        <= w_idx_next;
      r_cnt        <= w_cnt_next;
      r_loaded     <= w_loaded_next;
      r_addr       <= w_addr_next;
      r_wren_ref   <= w_wren_ref_next;
      r_wren_lease <= w_wren_lease_next;
      r_rmen       <= w_rmen_next;
      r_ref_addr   <= w_ref_addr_next;
      r_ref_lease  <= w_ref_lease_next;
      r_done       <= w_done_next;
      r_error      <= w_error_next;
    end
  end

  assign llt_bus.ready_o         = w_ready;
  assign llt_bus.addr_o          = r_addr;
  assign llt_bus.wren_ref_addr_o = r_wren_ref;
  assign llt_bus.wren_lease_o    = r_wren_lease;
  assign llt_bus.rmen_o          = r_rmen;
  assign llt_bus.ref_addr_o      = r_ref_addr;
  assign llt_bus.ref_lease_o     = r_ref_lease;
  assign busy_o                  = (r_state != S_IDLE);
  assign done_o                  = r_done;
  assign error_o                 = r_error;
  assign loaded_o                = r_loaded;
endmodule

// File: tb/tb_lease_table_loader.sv
// Bench for lease_table_loader: scoreboard of expected LLT strobes, a small LLT
// model fed by the strobes, table-driven loads and hand-written corner sequences.
module tb_lease_table_loader;
  localparam int N  = 128;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic clear;
  logic busy, done, error;
  logic [AW-1:0] loaded;

  always #5 clk = ~clk;

  lease_table_loader_if #(.BW_ADDR(AW)) bus ();

  lease_table_loader #(.N_ENTRIES(N)) dut (
    .clock_i (clk),
    .reset_i (rst),
    .start_i (start),
    .clear_i (clear),
    .llt_bus (bus),
    .busy_o  (busy),
    .done_o  (done),
    .error_o (error),
    .loaded_o(loaded)
  );

  // kind: 0 = no strobe (done/error only), 1 = remove, 2 = ref-addr write, 3 = lease write
  typedef struct {
    logic [1:0]    kind;
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic          dn;
    logic          er;
  } ev_t;

  typedef struct {
    logic [31:0] hdr;
    int          stall;
    bit          spec;
    int          n_ent;
    bit          exp_err;
    logic [AW-1:0] exp_loaded;
    bit          srch;
    logic [31:0] s_ref;
    logic [31:0] s_l0;
    logic [31:0] s_l1;
    logic [31:0] s_prob;
  } vec_t;

  ev_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;

  logic [31:0] m_ref0[N];
  logic [31:0] m_l0[N];
  logic [31:0] m_l1[N];
  logic [31:0] m_prob[N];
  bit          m_valid[N];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_ev(input logic [1:0] k, input logic [AW-1:0] a, input logic [31:0] d,
                         input logic dn, input logic er);
    ev_t e;
    e.kind = k; e.addr = a; e.data = d; e.dn = dn; e.er = er;
    exp_q.push_back(e);
  endtask

  function automatic int search(input logic [31:0] r);
    for (int i = 0; i < N; i++)
      if (m_valid[i] && m_ref0[i] == r) return i;
    return -1;
  endfunction

  task automatic check_search(input logic [31:0] r, input bit hit, input logic [31:0] l0,
                              input logic [31:0] l1, input logic [31:0] p);
    int idx;
    idx = search(r);
    chk("search_hit", 64'(idx >= 0), 64'(hit));
    if (hit && idx >= 0) begin
      chk("search_lease0", 64'(m_l0[idx]), 64'(l0));
      chk("search_lease1", 64'(m_l1[idx]), 64'(l1));
      chk("search_prob", 64'(m_prob[idx]), 64'(p));
    end
  endtask

  // Monitor: every strobe/done/error cycle is compared against the scoreboard.
  always @(negedge clk) begin
    int ns;
    ev_t e;
    logic [1:0] k;
    ns = int'(bus.rmen_o) + int'(bus.wren_ref_addr_o) + int'(bus.wren_lease_o);
    if (ns > 1) begin
      checks++; failures++;
      $display("FAIL multi_strobe: %0d strobes in one cycle, expected at most 1", ns);
    end
    if (ns != 0 || done || error) begin
      k = bus.rmen_o ? 2'd1 : bus.wren_ref_addr_o ? 2'd2 : bus.wren_lease_o ? 2'd3 : 2'd0;
      if (k == 2'd1 && !bus.addr_o[AW-1]) m_valid[bus.addr_o[AW-2:0]] = 1'b0;
      if (k == 2'd2) begin
        if (bus.addr_o[AW-1]) m_l1[bus.addr_o[AW-2:0]] = bus.ref_addr_o;
        else                  m_ref0[bus.addr_o[AW-2:0]] = bus.ref_addr_o;
      end
      if (k == 2'd3) begin
        if (bus.addr_o[AW-1]) m_prob[bus.addr_o[AW-2:0]] = bus.ref_lease_o;
        else begin
          m_l0[bus.addr_o[AW-2:0]] = bus.ref_lease_o;
          m_valid[bus.addr_o[AW-2:0]] = 1'b1;
        end
      end
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event: kind=%0d addr=0x%0h done=%0b err=%0b, expected none",
                 k, bus.addr_o, done, error);
      end else begin
        e = exp_q.pop_front();
        if (k !== e.kind || done !== e.dn || error !== e.er ||
            (k != 2'd0 && bus.addr_o !== e.addr) ||
            (k == 2'd2 && bus.ref_addr_o !== e.data) ||
            (k == 2'd3 && bus.ref_lease_o !== e.data)) begin
          failures++;
          $display("FAIL event: got kind=%0d addr=0x%0h ra=0x%0h rl=0x%0h done=%0b err=%0b expected kind=%0d addr=0x%0h data=0x%0h done=%0b err=%0b",
                   k, bus.addr_o, bus.ref_addr_o, bus.ref_lease_o, done, error,
                   e.kind, e.addr, e.data, e.dn, e.er);
        end
      end
    end
  end

  function automatic logic [31:0] word(input bit spec, input int e, input int k);
    logic [31:0] sw[2][4];
    sw[0][0] = 32'h10; sw[0][1] = 32'h1FF; sw[0][2] = 32'h400; sw[0][3] = 32'h7;
    sw[1][0] = 32'h20; sw[1][1] = 32'h0AA; sw[1][2] = 32'h404; sw[1][3] = 32'h3;
    if (spec) return sw[e][k];
    case (k)
      0:       return 32'h1000 + 32'(e);
      1:       return 32'hFFFF_FE00 | 32'(e * 3);
      2:       return 32'h8000_0000 + 32'(e * 4);
      default: return 32'h5000_0000 + 32'(e);
    endcase
  endfunction

  task automatic send_word(input logic [31:0] w, input int stall);
    int cyc;
    if (stall == 1) begin bus.valid_i = 1'b0; @(posedge clk); #1; end
    if (stall == 2) repeat ($urandom_range(0, 2)) begin bus.valid_i = 1'b0; @(posedge clk); #1; end
    bus.valid_i = 1'b1;
    bus.data_i  = w;
    cyc = 0;
    while (!bus.ready_o && cyc < 100) begin @(posedge clk); #1; cyc++; end
    if (!bus.ready_o) begin
      checks++; failures++;
      $display("FAIL ready_timeout: ready_o=0 after %0d cycles, expected 1", cyc);
    end
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int cyc;
    cyc = 0;
    while (busy && cyc < budget) begin @(posedge clk); #1; cyc++; end
    chk("idle_within_budget", 64'(busy), 64'(0));
  endtask

  task automatic settle_and_check_queue();
    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'(0));
  endtask

  vec_t vecs[7];

  initial begin
    rst = 1'b1; start = 1'b1; clear = 1'b0;
    bus.valid_i = 1'b1; bus.data_i = 32'h2;

    // Reset held with valid/start asserted: nothing may move.
    repeat (3) begin
      @(negedge clk);
      chk("rst_ready", 64'(bus.ready_o), 64'(0));
      chk("rst_outputs", {bus.rmen_o, bus.wren_ref_addr_o, bus.wren_lease_o, busy, done, error,
                          bus.addr_o, loaded}, 64'(0));
    end
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0; bus.valid_i = 1'b0;
    @(negedge clk);
    chk("idle_outputs", {bus.ready_o, busy, done, error, loaded, bus.ref_addr_o}, 64'(0));
    @(posedge clk); #1;

    vecs[0] = '{32'd2,           0, 1'b1, 2,   1'b0, 8'd2,   1'b1, 32'h404, 32'h3, 32'h20, 32'hAA};
    vecs[1] = '{32'd2,           1, 1'b1, 2,   1'b0, 8'd2,   1'b1, 32'h400, 32'h7, 32'h10, 32'h1FF};
    vecs[2] = '{32'd129,         0, 1'b0, 0,   1'b1, 8'd2,   1'b1, 32'h404, 32'h3, 32'h20, 32'hAA};
    vecs[3] = '{32'd0,           0, 1'b0, 0,   1'b0, 8'd0,   1'b0, 32'h0,   32'h0, 32'h0,  32'h0};
    vecs[4] = '{32'd3,           2, 1'b0, 3,   1'b0, 8'd3,   1'b1, 32'h8000_0008, 32'h5000_0002, 32'h1002, 32'h6};
    vecs[5] = '{32'hABCD_0001,   0, 1'b0, 1,   1'b0, 8'd1,   1'b0, 32'h0,   32'h0, 32'h0,  32'h0};
    vecs[6] = '{32'd128,         2, 1'b0, 128, 1'b0, 8'd128, 1'b1, 32'h8000_01FC, 32'h5000_007F, 32'h107F, 32'h17D};

    for (int v = 0; v < 7; v++) begin
      if (vecs[v].exp_err)        push_ev(2'd0, '0, '0, 1'b0, 1'b1);
      else if (vecs[v].n_ent == 0) push_ev(2'd0, '0, '0, 1'b1, 1'b0);
      for (int e = 0; e < vecs[v].n_ent; e++) begin
        logic [AW-2:0] ix;
        ix = (AW-1)'(e);
        push_ev(2'd1, {1'b0, ix}, '0, 1'b0, 1'b0);
        push_ev(2'd2, {1'b1, ix}, word(vecs[v].spec, e, 0), 1'b0, 1'b0);
        push_ev(2'd3, {1'b1, ix}, {23'd0, word(vecs[v].spec, e, 1) & 32'h1FF}, 1'b0, 1'b0);
        push_ev(2'd2, {1'b0, ix}, word(vecs[v].spec, e, 2), 1'b0, 1'b0);
        push_ev(2'd3, {1'b0, ix}, word(vecs[v].spec, e, 3), e == vecs[v].n_ent - 1, 1'b0);
      end
      pulse_start();
      send_word(vecs[v].hdr, vecs[v].stall);
      for (int e = 0; e < vecs[v].n_ent; e++)
        for (int k = 0; k < 4; k++)
          send_word(word(vecs[v].spec, e, k), vecs[v].stall);
      wait_idle(2000);
      settle_and_check_queue();
      chk($sformatf("loaded_v%0d", v), 64'(loaded), 64'(vecs[v].exp_loaded));
      if (vecs[v].srch)
        check_search(vecs[v].s_ref, 1'b1, vecs[v].s_l0, vecs[v].s_l1, vecs[v].s_prob);
      $display("load vec=%0d hdr=0x%0h stall=%0d loaded=%0d", v, vecs[v].hdr, vecs[v].stall, loaded);
    end

    // Clear wins over a simultaneous start; offered words must not be taken.
    begin
      bit ready_seen;
      int cyc;
      for (int i = 0; i < N; i++) push_ev(2'd1, AW'(i), '0, i == N - 1, 1'b0);
      clear = 1'b1; start = 1'b1; bus.valid_i = 1'b1; bus.data_i = 32'd2;
      @(posedge clk); #1;
      clear = 1'b0; start = 1'b0;
      ready_seen = 1'b0; cyc = 0;
      while (busy && cyc < 300) begin
        if (bus.ready_o) ready_seen = 1'b1;
        @(posedge clk); #1; cyc++;
      end
      bus.valid_i = 1'b0;
      chk("clear_idle_within_budget", 64'(busy), 64'(0));
      chk("clear_ready_low", 64'(ready_seen), 64'(0));
      chk("clear_cycles", 64'(cyc), 64'(N));
      settle_and_check_queue();
      check_search(32'h8000_0004, 1'b0, 0, 0, 0);
      $display("clear cycles=%0d", cyc);
    end

    // Reset after the PROB word of entry 0: entry stays invalid.
    push_ev(2'd1, 8'h00, '0, 1'b0, 1'b0);
    push_ev(2'd2, 8'h80, 32'h77, 1'b0, 1'b0);
    push_ev(2'd3, 8'h80, 32'h55, 1'b0, 1'b0);
    pulse_start();
    send_word(32'd1, 0);
    send_word(32'h77, 0);
    send_word(32'h55, 0);
    rst = 1'b1;
    bus.valid_i = 1'b1; bus.data_i = 32'hDEAD_0000;
    @(posedge clk); #1;
    chk("midrst_busy", 64'(busy), 64'(0));
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
    chk("midrst_loaded", 64'(loaded), 64'(0));
    chk("midrst_entry0_valid", 64'(m_valid[0]), 64'(0));
    settle_and_check_queue();
    check_search(32'hDEAD_0000, 1'b0, 0, 0, 0);
    $display("midreset busy=%0d loaded=%0d", busy, loaded);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
